// File: rtl/fetch_decouple_fifo_pkg.sv
// Shared types for the fetch decoupling buffer: the frontend fetch entry and its sub-fields.
package fetch_decouple_fifo_pkg;

  // Depth used by the frontend/ID wrapper when instantiating the buffer.
  localparam int unsigned FETCH_FIFO_DEPTH = 8;

  localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    cf_t         cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]        address;
    logic [31:0]        instruction;
    branchpredict_sbe_t branch_predict;
    exception_t         ex;
  } frontend_fetch_t;

endpackage

// File: rtl/fetch_decouple_fifo.sv
// Show-ahead FIFO between the frontend and the ID stage; oldest entry is always presented,
// flush purges everything, and ready/afull/usage depend on registered occupancy only.
module fetch_decouple_fifo
  import fetch_decouple_fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AFULL_TH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  frontend_fetch_t            fetch_entry_i,
  input  logic                       fetch_entry_valid_i,
  output logic                       fetch_entry_ready_o,
  output frontend_fetch_t            fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_ack_i,
  output logic                       afull_o,
  output logic [$clog2(DEPTH):0]     usage_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  frontend_fetch_t       mem_q [DEPTH];
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fetch_entry_ready_o = (count_q != CntW'(DEPTH));
  assign fetch_entry_valid_o = (count_q != '0);
  assign fetch_entry_o       = mem_q[rptr_q];
  assign afull_o             = (count_q >= CntW'(DEPTH - AFULL_TH));
  assign usage_o             = count_q;

  assign push = fetch_entry_valid_i & fetch_entry_ready_o & ~flush_i;
  assign pop  = fetch_ack_i & fetch_entry_valid_o & ~flush_i;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush_i) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = next_ptr(wptr_q);
      if (pop)  rptr_d = next_ptr(rptr_q);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; only slots behind a valid count are ever observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= fetch_entry_i;
  end

`ifndef SYNTHESIS
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CntW'(DEPTH));

  a_no_ack_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    fetch_ack_i |-> fetch_entry_valid_o);

  a_push_stable : assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    (fetch_entry_valid_i && !fetch_entry_ready_o)
      |=> (fetch_entry_valid_i && $stable(fetch_entry_i)));
`endif

endmodule
